seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit, 7-segment display. It snapshots the 32-bit nibble word and 8-bit digit-enable vector from the UART byte decoder, then drives one digit at a time with the correct segment pattern. Each digit slot has an anti-ghosting blank interval and 16-level brightness control. It sits between the decoder outputs and the board's segment/digit pins.

## Interface
Parameters:
- BLANK_CYCLES, default 120: all-digits-off cycles at the start of every digit slot; must be ≥1.
- STEP_CYCLES, default 742: cycles per brightness step; must be ≥1.
- Slot length: DIGIT_CYCLES = BLANK_CYCLES + 16*STEP_CYCLES. With the defaults this is 11992 cycles, about 1 ms at 12 MHz.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- seg_data  input  32  digit nibbles; [4i+3:4i] is digit i; digit 0 is rightmost, newest.
- data_en  input  8  bit i enables digit i.
- dp_en  input  8  bit i lights the decimal point of digit i.
- brightness  input  4  on-time in steps minus 1 (0 = 1/16, 15 = 16/16 of the active window).
- seg_out  output  8  active-low segments; bit0=a … bit6=g, bit7=dp.
- dig_sel  output  8  active-low digit select; bit i = digit i.
- frame_start  output  1  one-cycle pulse on the first cycle of slot 0; coincides with the shadow load.

## Operation
- Shadow registers:
  - Hold seg_data, data_en, dp_en and brightness.
  - Load on the frame_start cycle only.
  - Input changes mid-frame never affect the current frame; this covers the decoder's asynchronous update strobe.
- Counters:
  - cyc: 0..max(BLANK_CYCLES, STEP_CYCLES)-1.
  - step: 0..15.
  - digit: 0..7.
- Per-slot state machine:
  - BLANK → ON when BLANK_CYCLES cycles have elapsed.
  - ON → OFF when (b+1)*STEP_CYCLES cycles have elapsed in ON, where b is the shadow brightness.
  - OFF → BLANK (next digit) when the slot ends.
  - When b=15, the OFF duration is zero: ON → BLANK of the next digit directly.
- Digit advance: digit increments at slot end, wrapping 7→0. The 7→0 wrap asserts frame_start and reloads the shadows.
- Driving a digit in ON: dig_sel bit i is low only if shadow data_en[i]=1. Otherwise dig_sel stays 8'hFF and seg_out stays 8'hFF for the whole slot, but slot timing is unchanged.
- Segment decode in ON, hex, active-low, bits[6:0]:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - Bit 7 is the inverse of shadow dp_en[i].
- Outside ON (BLANK, OFF, or digit disabled): seg_out=8'hFF, dig_sel=8'hFF.
- At most one dig_sel bit is low at any time.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values:
  - seg_out=8'hFF, dig_sel=8'hFF, frame_start=0.
  - All shadows 0; cyc=0, step=0, digit=0.
  - State is a pre-load state.
- First clk edge after rst_n deasserts: frame_start=1, shadows load, state BLANK, digit 0. Call this t=0.
- Slot timing, relative to slot start s (slot 0 starts at t=0, slot k at k*DIGIT_CYCLES):
  - Digit k's dig_sel/seg_out are active for cycles [s+BLANK_CYCLES, s+BLANK_CYCLES+(b+1)*STEP_CYCLES).
  - These are the cycles on which the registered outputs show the value.
- Frame timing:
  - Frame period is 8*DIGIT_CYCLES.
  - frame_start pulses exactly once per frame, never two cycles in a row.
- Latency: an input change is visible no later than the first ON window of the frame after the next frame_start.
- Reset mid-slot: outputs return to FF/FF/0 immediately (asynchronous); the sequence restarts as after power-up.
- Brightness sampled at frame start applies to all 8 slots of that frame.

## Test plan
All scenarios use BLANK_CYCLES=2, STEP_CYCLES=1, giving DIGIT_CYCLES=18 and a frame of 144 cycles.
- Reset / first frame: release reset with seg_data=32'h76543210, data_en=FF, dp_en=00, brightness=F.
  - frame_start at t=0.
  - Digit 0: dig_sel=FE, seg_out=C0 for t=2..17.
  - Digit 1: dig_sel=FD, seg_out=F9 for t=20..35.
  - Digit 7: dig_sel=7F, seg_out=F8 for t=128..143.
  - Next frame_start at t=144.
- Brightness 0: brightness=0, data_en=01.
  - dig_sel=FE for exactly one cycle (t=2) per frame.
  - All other cycles FF.
- Disabled digits and decimal point: data_en=8'h05, dp_en=8'h04, seg_data nibble2=8.
  - Only slots 0 and 2 drive.
  - Slot 2 has seg_out=00 and dig_sel=FB.
  - Slots 1 and 3..7 are FF/FF for their full 18 cycles.
- Shadow isolation: change seg_data 32'h0→32'hFFFFFFFF at t=50 (mid-frame).
  - Frame 0 shows all C0 patterns.
  - Frame 1 (from t=144) shows 8E on every digit.
- Hex decode: sweep nibble0 through 0..F across 16 frames.
  - seg_out at t=2 of each frame matches the decode list in Operation.
- Mid-operation reset: assert rst_n=0 at t=70.
  - seg_out=FF and dig_sel=FF on the same cycle.
  - After release: frame_start at the first edge, then the normal slot-0 sequence.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 8-digit 7-segment scan controller
//
// Purpose: snapshots the digit nibbles, enables, decimal points and brightness
// once per frame, then drives one digit per slot. Each slot has a blank
// interval, an ON window of (b+1) brightness steps, and an OFF remainder.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   seg_data_i     digit nibbles, [4i+3:4i] is digit i
//   data_en_i      per-digit enable
//   dp_en_i        per-digit decimal point
//   brightness_i   on-time in steps minus 1
//   seg_out_o      active-low segments, bit0=a .. bit6=g, bit7=dp
//   dig_sel_o      active-low digit select
//   frame_start_o  one-cycle pulse on the first cycle of slot 0
module seg_scan_ctrl #(
  parameter int unsigned BLANK_CYCLES = 120,
  parameter int unsigned STEP_CYCLES  = 742
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] seg_data_i,
  input  logic [7:0]  data_en_i,
  input  logic [7:0]  dp_en_i,
  input  logic [3:0]  brightness_i,
  output logic [7:0]  seg_out_o,
  output logic [7:0]  dig_sel_o,
  output logic        frame_start_o
);

  localparam int unsigned CMAX = (BLANK_CYCLES > STEP_CYCLES) ? BLANK_CYCLES : STEP_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {S_LOAD, S_BLANK, S_ON, S_OFF} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    step_q, step_d;
  logic [2:0]    digit_q, digit_d;
  logic [31:0]   sd_q;
  logic [7:0]    en_q, dp_q;
  logic [3:0]    br_q;
  logic [7:0]    seg_q, seg_d, dig_q, dig_d;
  logic          fs_q;
  logic          load, slot_end;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    step_d   = step_q;
    digit_d  = digit_q;
    load     = 1'b0;
    slot_end = 1'b0;
    case (state_q)
      S_LOAD: begin
        state_d = S_BLANK;
        cyc_d   = '0;
        step_d  = '0;
        digit_d = '0;
        load    = 1'b1;
      end
      S_BLANK: begin
        if (cyc_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = S_ON;
          cyc_d   = '0;
          step_d  = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_ON: begin
        if (cyc_q == CW'(STEP_CYCLES - 1)) begin
          cyc_d = '0;
          if (step_q == 4'hF) begin
            // Full brightness: no OFF interval, go straight to the next slot.
            slot_end = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
            if (step_q == br_q) state_d = S_OFF;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        if (cyc_q == CW'(STEP_CYCLES - 1)) begin
          cyc_d = '0;
          if (step_q == 4'hF) slot_end = 1'b1;
          else                step_d   = step_q + 4'd1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
    endcase

    if (slot_end) begin
      state_d = S_BLANK;
      cyc_d   = '0;
      step_d  = '0;
      digit_d = digit_q + 3'd1;
      load    = (digit_q == 3'd7);
    end

    // Outputs are registered from the next state so they line up with it.
    seg_d = 8'hFF;
    dig_d = 8'hFF;
    if (state_d == S_ON && en_q[digit_d]) begin
      dig_d = ~(8'h01 << digit_d);
      seg_d = {~dp_q[digit_d], hex7(sd_q[4*digit_d +: 4])};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_LOAD;
      cyc_q   <= '0;
      step_q  <= '0;
      digit_q <= '0;
      sd_q    <= '0;
      en_q    <= '0;
      dp_q    <= '0;
      br_q    <= '0;
      seg_q   <= 8'hFF;
      dig_q   <= 8'hFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      step_q  <= step_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      fs_q    <= load;
      if (load) begin
        sd_q <= seg_data_i;
        en_q <= data_en_i;
        dp_q <= dp_en_i;
        br_q <= brightness_i;
      end
    end
  end

  assign seg_out_o     = seg_q;
  assign dig_sel_o     = dig_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] seg_data;
  logic [7:0]  data_en, dp_en;
  logic [3:0]  brightness;
  logic [7:0]  seg_out, dig_sel;
  logic        frame_start;

  int pass  = 0;
  int total = 0;

  seg_scan_ctrl #(.BLANK_CYCLES(2), .STEP_CYCLES(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .seg_data_i(seg_data), .data_en_i(data_en),
    .dp_en_i(dp_en), .brightness_i(brightness), .seg_out_o(seg_out),
    .dig_sel_o(dig_sel), .frame_start_o(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hex_pat(input logic [3:0] n);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[n];
  endfunction

  task automatic check(input string tag, input int off, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s off=%0d got=%h expected=%h", tag, off, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with the sample of frame offset 0 already taken; checks all 144
  // cycles and returns positioned at offset 0 of the next frame.
  task automatic check_frame(input logic [31:0] sd, input logic [7:0] en, input logic [7:0] dp,
                             input logic [3:0] b, input int chg_at, input logic [31:0] chg_val);
    for (int off = 0; off < 144; off++) begin
      int slot, p;
      logic act;
      logic [7:0] e_dig, e_seg, pat;
      slot  = off / 18;
      p     = off % 18;
      act   = en[slot] && (p >= 2) && (p < 3 + int'(b));
      pat   = hex_pat(sd[4*slot +: 4]);
      e_dig = act ? ~(8'h01 << slot) : 8'hFF;
      e_seg = act ? {~dp[slot], pat[6:0]} : 8'hFF;
      check("dig_sel", off, {24'h0, dig_sel}, {24'h0, e_dig});
      check("seg_out", off, {24'h0, seg_out}, {24'h0, e_seg});
      check("frame_start", off, {31'h0, frame_start}, {31'h0, (off == 0)});
      if (off == chg_at) seg_data = chg_val;
      step();
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    seg_data   = 32'h76543210;
    data_en    = 8'hFF;
    dp_en      = 8'h00;
    brightness = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg_out", -1, {24'h0, seg_out}, 32'hFF);
    check("rst_dig_sel", -1, {24'h0, dig_sel}, 32'hFF);
    check("rst_frame_start", -1, {31'h0, frame_start}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Frame 0: all digits, full brightness. Queue brightness-0 frame next.
    seg_data = 32'h0; data_en = 8'h01; dp_en = 8'h00; brightness = 4'h0;
    check_frame(32'h76543210, 8'hFF, 8'h00, 4'hF, -1, 32'h0);

    // Frame 1: brightness 0, only digit 0.
    seg_data = 32'h00000800; data_en = 8'h05; dp_en = 8'h04; brightness = 4'hF;
    check_frame(32'h0, 8'h01, 8'h00, 4'h0, -1, 32'h0);

    // Frame 2: disabled digits and decimal point on digit 2.
    seg_data = 32'h0; data_en = 8'hFF; dp_en = 8'h00; brightness = 4'hF;
    check_frame(32'h00000800, 8'h05, 8'h04, 4'hF, -1, 32'h0);

    // Frame 3: seg_data flips at offset 50 but must not show until next frame.
    check_frame(32'h0, 8'hFF, 8'h00, 4'hF, 50, 32'hFFFFFFFF);

    // Frame 4: new data visible on every digit.
    seg_data = 32'h0; data_en = 8'h01; brightness = 4'h3;
    check_frame(32'hFFFFFFFF, 8'hFF, 8'h00, 4'hF, -1, 32'h0);

    // Frames 5..20: hex decode sweep of digit 0.
    for (int n = 0; n < 16; n++) begin
      seg_data = 32'(n + 1);
      if (n == 15) begin
        seg_data = 32'h76543210; data_en = 8'hFF; brightness = 4'hF;
      end
      check_frame(32'(n), 8'h01, 8'h00, 4'h3, -1, 32'h0);
    end

    // Mid-operation reset at offset 70 (digit 3 lit).
    for (int off = 0; off < 70; off++) step();
    check("pre_rst_dig_sel", 70, {24'h0, dig_sel}, 32'hF7);
    check("pre_rst_seg_out", 70, {24'h0, seg_out}, 32'hB0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_seg_out", 70, {24'h0, seg_out}, 32'hFF);
    check("mid_rst_dig_sel", 70, {24'h0, dig_sel}, 32'hFF);
    check("mid_rst_frame_start", 70, {31'h0, frame_start}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_frame(32'h76543210, 8'hFF, 8'h00, 4'hF, -1, 32'h0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
